arith_unit_mc: RTL
==================

Name: arith_unit_mc

Overview:
Parametrised, multi-cycle successor to the CPU's combinational add/sub arithmetic unit. It keeps the mode-01 instruction opcodes 100 ADD and 101 SUB. It adds carry-chained ADC/SBC, a flags-only CMP, and a signed shift-add MUL. Results and a persistent NZVC flag register are registered, and a start/busy/done handshake lets the control unit stall on multi-cycle ops.

Parameters:
WIDTH, 8, datapath width in bits (>=4)
MUL_ENABLE, 1, 1 = opcode 110 performs MUL; 0 = 110 is treated as illegal

Ports:
clock  input  1  single system clock, all state on rising edge
reset  input  1  synchronous, active-high reset
start  input  1  request; accepted on an edge where start=1 and busy=0
opcode  input  3  operation select, sampled on accept
operandA  input  WIDTH  signed operand A, sampled on accept
operandB  input  WIDTH  signed operand B, sampled on accept
busy  output  1  high while a MUL is in progress
done  output  1  one-cycle pulse: result/flags valid for the op just completed
result  output  WIDTH  registered result (low half for MUL)
result_hi  output  WIDTH  high half of MUL product; 0 after all other ops
flags  output  4  {N,Z,V,C}, persistent between ops

Behaviour:
- Reset is synchronous only (no async path): result=0, result_hi=0, flags=0, busy=0, done=0, FSM=IDLE. Reset wins over start; reset during MUL aborts it, and no done pulse follows.
- Opcodes: 000 ADC A+B+C; 001 SBC A-B-C; 100 ADD; 101 SUB; 110 MUL; 111 CMP (A-B, flags only, result/result_hi held); 010/011 illegal.
- Single-cycle ops (everything except MUL): if accepted on edge k, result/flags update on edge k, and done=1 for the cycle after edge k. busy stays 0.
- MUL: if accepted on edge k, operands are latched and busy=1 after edge k. The FSM runs WIDTH iterations. On edge k+WIDTH, result/result_hi/flags update, busy drops to 0, and done=1 for one cycle. Latency is WIDTH cycles.
- FSM: IDLE -> MUL_RUN on accept of MUL; MUL_RUN counts 0..WIDTH-1 -> IDLE on last iteration. Single-cycle ops stay in IDLE.
- While busy: start is ignored, not queued. Input changes have no effect.
- Start is accepted in the same cycle that done is high, giving back-to-back ops with no bubble.
- Add/sub width rules: compute in WIDTH+1 bits, and result is the low WIDTH bits (wrap-around).
  - C on add = carry out.
  - C on sub/SBC/CMP = borrow (1 when A <u B+Cin).
  - V = signed overflow.
  - N = result MSB.
  - Z = (result==0).
- MUL is signed x signed, computed as a magnitude product with final negation. Full product is 2*WIDTH bits: {result_hi, result}.
  - N = product MSB.
  - Z = (product==0).
  - C = V = 1 when result_hi is not the sign-extension of result.
- Illegal opcode: result=0, result_hi=0, flags unchanged, done after 1 cycle. The op never hangs.
- flags change only on an op completion or on reset.

Decomposition:
- Package arith_pkg:
  - opcode enum: ADC, SBC, ADD, SUB, MUL, CMP.
  - flag bit index constants: N=3, Z=2, V=1, C=0.
  - FSM state enum: IDLE, MUL_RUN.
- One sub-module, shift_add_multiplier: WIDTH-parametrised unsigned iterative multiplier with load/step/last interface. Sign handling and flags stay in the parent.

Test Plan:
- WIDTH=8, ADD 100+27 -> done after 1 cycle, result 0x7F, flags 0000; then ADD 100+28 -> result 0x80, N=1, V=1, C=0, Z=0.
- SUB 5-7 -> result 0xFE, N=1, C=1 (borrow), V=0; then CMP 9,9 -> result stays 0xFE, Z=1, C=0, N=0.
- ADD 0xFF+0x01 -> result 0x00, Z=1, C=1; then ADC 0+0 -> result 0x01, C=0, Z=0.
- MUL -3*7 -> busy for 8 cycles, done exactly 8 cycles after accept, result 0xEB, result_hi 0xFF, C=V=0. A start pulse at cycle 3 is ignored. MUL -128*-128 -> result 0x00, result_hi 0x40, C=V=1, Z=0.
- Illegal opcode 010 -> result 0, result_hi 0, flags unchanged from the prior op, done after 1 cycle. ADD started in the done cycle of a MUL completes on the next cycle.
- Reset asserted on cycle 4 of a MUL -> next cycle busy=0, done=0, result=0, flags=0, and no done pulse for the remainder of the original 8 cycles.

Source files
------------

// File: rtl/arith_pkg.sv
// rtl/arith_pkg.sv - opcodes, flag bit positions and FSM states shared by arith_unit_mc
package arith_pkg;

  typedef enum logic [2:0] {
    OP_ADC = 3'b000,
    OP_SBC = 3'b001,
    OP_ADD = 3'b100,
    OP_SUB = 3'b101,
    OP_MUL = 3'b110,
    OP_CMP = 3'b111
  } opcode_e;

  localparam int FLAG_N = 3;
  localparam int FLAG_Z = 2;
  localparam int FLAG_V = 1;
  localparam int FLAG_C = 0;

  typedef enum logic {
    IDLE    = 1'b0,
    MUL_RUN = 1'b1
  } state_e;

  function automatic logic [3:0] pack_flags(input logic n, input logic z,
                                            input logic v, input logic c);
    logic [3:0] f;
    f         = '0;
    f[FLAG_N] = n;
    f[FLAG_Z] = z;
    f[FLAG_V] = v;
    f[FLAG_C] = c;
    return f;
  endfunction

endpackage

// File: rtl/shift_add_multiplier.sv
// rtl/shift_add_multiplier.sv - unsigned iterative shift-add multiplier, one partial product per step
module shift_add_multiplier #(
  parameter int WIDTH = 8
) (
  input  logic               clock_i,
  input  logic               reset_i,
  input  logic               load_i,
  input  logic               step_i,
  input  logic [WIDTH-1:0]   a_i,
  input  logic [WIDTH-1:0]   b_i,
  output logic               last_o,
  output logic [2*WIDTH-1:0] product_next_o
);

  localparam int CW = $clog2(WIDTH);

  logic [WIDTH-1:0]   a_q, a_d;
  logic [2*WIDTH-1:0] p_q, p_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [WIDTH:0]     sum;

  // Upper half accumulates, lower half holds the not-yet-consumed multiplier bits.
  always_comb begin
    sum            = {1'b0, p_q[2*WIDTH-1:WIDTH]} + (p_q[0] ? {1'b0, a_q} : '0);
    product_next_o = {sum, p_q[WIDTH-1:1]};
    a_d            = a_q;
    p_d            = p_q;
    cnt_d          = cnt_q;
    if (load_i) begin
      a_d   = a_i;
      p_d   = {{WIDTH{1'b0}}, b_i};
      cnt_d = '0;
    end else if (step_i) begin
      p_d   = product_next_o;
      cnt_d = cnt_q + CW'(1);
    end
  end

  assign last_o = (cnt_q == CW'(WIDTH - 1));

  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      a_q   <= '0;
      p_q   <= '0;
      cnt_q <= '0;
    end else begin
      a_q   <= a_d;
      p_q   <= p_d;
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/arith_unit_mc.sv
// rtl/arith_unit_mc.sv - registered add/sub/compare unit with NZVC flags and multi-cycle signed multiply
module arith_unit_mc
  import arith_pkg::*;
#(
  parameter int WIDTH      = 8,
  parameter bit MUL_ENABLE = 1'b1
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic [2:0]       opcode,
  input  logic [WIDTH-1:0] operandA,
  input  logic [WIDTH-1:0] operandB,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic [WIDTH-1:0] result_hi,
  output logic [3:0]       flags
);

  localparam int MSB = WIDTH - 1;

  state_e             state_q, state_d;
  logic [WIDTH-1:0]   result_q, result_d;
  logic [WIDTH-1:0]   hi_q, hi_d;
  logic [3:0]         flags_q, flags_d;
  logic               done_q, done_d;
  logic               sign_q, sign_d;

  logic               accept;
  logic               mul_load, mul_step, mul_last;
  logic [WIDTH-1:0]   mag_a, mag_b;
  logic [2*WIDTH-1:0] mul_next, mul_prod;
  logic               mul_ovf;
  logic [3:0]         mul_flags;

  logic               is_sub, cin, as_v;
  logic [WIDTH:0]     as_full;
  logic [WIDTH-1:0]   as_res;
  logic [3:0]         as_flags;

  assign accept = start && (state_q == IDLE);

  // Opcode bit 0 selects subtract; bit 2 clear selects the carry-chained variants.
  always_comb begin
    is_sub = opcode[0];
    cin    = !opcode[2] && flags_q[FLAG_C];
    if (is_sub) begin
      as_full = {1'b0, operandA} - {1'b0, operandB} - {{WIDTH{1'b0}}, cin};
    end else begin
      as_full = {1'b0, operandA} + {1'b0, operandB} + {{WIDTH{1'b0}}, cin};
    end
    as_res = as_full[WIDTH-1:0];
    if (is_sub) begin
      as_v = (operandA[MSB] != operandB[MSB]) && (as_res[MSB] != operandA[MSB]);
    end else begin
      as_v = (operandA[MSB] == operandB[MSB]) && (as_res[MSB] != operandA[MSB]);
    end
    as_flags = pack_flags(as_res[MSB], as_res == '0, as_v, as_full[WIDTH]);
  end

  always_comb begin
    mag_a    = operandA[MSB] ? (~operandA + WIDTH'(1)) : operandA;
    mag_b    = operandB[MSB] ? (~operandB + WIDTH'(1)) : operandB;
    mul_prod = sign_q ? (~mul_next + (2*WIDTH)'(1)) : mul_next;
    mul_ovf  = mul_prod[2*WIDTH-1:WIDTH] != {WIDTH{mul_prod[MSB]}};
    mul_flags = pack_flags(mul_prod[2*WIDTH-1], mul_prod == '0, mul_ovf, mul_ovf);
  end

  shift_add_multiplier #(
    .WIDTH(WIDTH)
  ) u_mul (
    .clock_i       (clock),
    .reset_i       (reset),
    .load_i        (mul_load),
    .step_i        (mul_step),
    .a_i           (mag_a),
    .b_i           (mag_b),
    .last_o        (mul_last),
    .product_next_o(mul_next)
  );

  always_comb begin
    state_d  = state_q;
    result_d = result_q;
    hi_d     = hi_q;
    flags_d  = flags_q;
    done_d   = 1'b0;
    sign_d   = sign_q;
    mul_load = 1'b0;
    mul_step = 1'b0;
    case (state_q)
      IDLE: begin
        if (accept) begin
          if ((opcode == OP_MUL) && MUL_ENABLE) begin
            state_d  = MUL_RUN;
            mul_load = 1'b1;
            sign_d   = operandA[MSB] ^ operandB[MSB];
          end else begin
            done_d = 1'b1;
            case (opcode)
              OP_ADC, OP_SBC, OP_ADD, OP_SUB: begin
                result_d = as_res;
                hi_d     = '0;
                flags_d  = as_flags;
              end
              OP_CMP: flags_d = as_flags;
              default: begin
                result_d = '0;
                hi_d     = '0;
              end
            endcase
          end
        end
      end
      MUL_RUN: begin
        mul_step = 1'b1;
        if (mul_last) begin
          state_d  = IDLE;
          done_d   = 1'b1;
          result_d = mul_prod[WIDTH-1:0];
          hi_d     = mul_prod[2*WIDTH-1:WIDTH];
          flags_d  = mul_flags;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q  <= IDLE;
      result_q <= '0;
      hi_q     <= '0;
      flags_q  <= '0;
      done_q   <= 1'b0;
      sign_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      result_q <= result_d;
      hi_q     <= hi_d;
      flags_q  <= flags_d;
      done_q   <= done_d;
      sign_q   <= sign_d;
    end
  end

  assign busy      = (state_q == MUL_RUN);
  assign done      = done_q;
  assign result    = result_q;
  assign result_hi = hi_q;
  assign flags     = flags_q;

endmodule
